// File: rtl/proc72_pkg.sv
// proc72_pkg: shared constants for the 72-bit processor.
// Holds the instruction field layout, default bus widths and the fetch
// queue state encoding.
package proc72_pkg;

  localparam int P72_DATA_W = 72;
  localparam int P72_ADDR_W = 72;

  localparam int OPCODE_MSB = 71;
  localparam int OPCODE_LSB = 68;
  localparam int RS1_MSB    = 67;
  localparam int RS1_LSB    = 62;
  localparam int RS2_MSB    = 61;
  localparam int RS2_LSB    = 56;
  localparam int RD_MSB     = 55;
  localparam int RD_LSB     = 50;
  localparam int IMM_MSB    = 49;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 54;
  localparam int JADDR_LSB  = 0;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_REQ  = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_e;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: redirect, instruction memory and decode-side
// signals of the fetch queue. The master modport is the fetch queue
// itself; the slave modport is its surroundings.
// Optional IFQ_STATS_EN adds the stat_fetched/stat_dropped counters.
interface instr_fetch_queue_if
  import proc72_pkg::*;
#(
  parameter int DATA_W = P72_DATA_W,
  parameter int ADDR_W = P72_ADDR_W,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_addr;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic [CNT_W-1:0]  count;
`ifdef IFQ_STATS_EN
  logic [31:0]       stat_fetched;
  logic [31:0]       stat_dropped;
`endif

  modport master (
    input  redirect_en, redirect_addr, imem_ack, imem_rdata, instr_ready,
`ifdef IFQ_STATS_EN
    output stat_fetched, stat_dropped,
`endif
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc, count
  );

  modport slave (
    output redirect_en, redirect_addr, imem_ack, imem_rdata, instr_ready,
`ifdef IFQ_STATS_EN
    input  stat_fetched, stat_dropped,
`endif
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc, count
  );

endinterface

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry synchronous FIFO holding {instruction, pc} words.
// Flush empties it in one cycle; pushes when full and pops when empty are
// ignored. The head is forced to zero while empty.
module ifq_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             empty, full, pushOk, popOk;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign pushOk = push_i & ~full & ~flush_i;
  assign popOk  = pop_i & ~empty & ~flush_i;

  // Storage array: written only by an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= wdata_i;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(pushOk) - CNT_W'(popOk);
    end
  end

  assign rdata_o = empty ? '0 : mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: owns the fetch PC, issues one-at-a-time requests to
// instruction memory and buffers returned words with their PC for decode.
// A redirect flushes the buffer; an in-flight request is drained and its
// data discarded. Optional IFQ_STATS_EN adds fetched/dropped counters.
module instr_fetch_queue
  import proc72_pkg::*;
#(
  parameter int                DATA_W   = P72_DATA_W,
  parameter int                ADDR_W   = P72_ADDR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_queue_if.master bus
);
  localparam int               CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  ifq_state_e               state_q, state_d;
  logic [ADDR_W-1:0]        fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0]        dropAddr_q, dropAddr_d;
  logic [CNT_W-1:0]         count, countAfterPop;
  logic                     reqActive, ackFire, popFire, pushEn;
  logic [DATA_W+ADDR_W-1:0] headWord;

  assign reqActive     = (state_q != IFQ_IDLE);
  assign ackFire       = bus.imem_ack & reqActive;
  assign popFire       = (count != '0) & bus.instr_ready;
  assign countAfterPop = count - CNT_W'(popFire);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IFQ_IDLE;
    else      state_q <= state_d;
  end

  // Fetch PC and the address of a request being drained after a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc_q  <= RESET_PC;
      dropAddr_q <= RESET_PC;
    end else begin
      fetchPc_q  <= fetchPc_d;
      dropAddr_q <= dropAddr_d;
    end
  end

  // Next state: redirect wins over push; keep requesting only while a slot stays free.
  always_comb begin
    state_d    = state_q;
    fetchPc_d  = fetchPc_q;
    dropAddr_d = dropAddr_q;
    pushEn     = 1'b0;
    if (bus.redirect_en) fetchPc_d = bus.redirect_addr;
    case (state_q)
      IFQ_IDLE: begin
        if (!bus.redirect_en && (count < FULL_C)) state_d = IFQ_REQ;
      end
      IFQ_REQ: begin
        if (bus.redirect_en) begin
          if (ackFire) begin
            state_d = IFQ_IDLE;
          end else begin
            state_d    = IFQ_DROP;
            dropAddr_d = fetchPc_q;
          end
        end else if (ackFire) begin
          pushEn    = 1'b1;
          fetchPc_d = fetchPc_q + ADDR_W'(1);
          state_d   = ((countAfterPop + ONE_C) < FULL_C) ? IFQ_REQ : IFQ_IDLE;
        end
      end
      IFQ_DROP: begin
        if (ackFire) begin
          state_d = (!bus.redirect_en && (countAfterPop < FULL_C)) ? IFQ_REQ : IFQ_IDLE;
        end
      end
      default: state_d = IFQ_IDLE;
    endcase
  end

  // Memory request outputs: a drained request keeps its original address.
  always_comb begin
    bus.imem_req  = reqActive;
    bus.imem_addr = (state_q == IFQ_DROP) ? dropAddr_q : fetchPc_q;
  end

  ifq_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pushEn),
    .pop_i   (popFire),
    .flush_i (bus.redirect_en),
    .wdata_i ({bus.imem_rdata, fetchPc_q}),
    .rdata_o (headWord),
    .count_o (count)
  );

  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = headWord[DATA_W+ADDR_W-1:ADDR_W];
  assign bus.instr_pc    = headWord[ADDR_W-1:0];
  assign bus.count       = count;

`ifdef IFQ_STATS_EN
  logic [31:0]      statFetched_q, statDropped_q;
  logic [CNT_W-1:0] flushed;
  logic             dropAck;
  logic [32:0]      dropSum;

  assign dropAck = ackFire & ((state_q == IFQ_DROP) | ((state_q == IFQ_REQ) & bus.redirect_en));
  assign flushed = bus.redirect_en ? countAfterPop : '0;
  assign dropSum = {1'b0, statDropped_q} + 33'(flushed) + 33'(dropAck);

  // Saturating event counters for pushed and discarded instructions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statFetched_q <= '0;
      statDropped_q <= '0;
    end else begin
      if (pushEn && (statFetched_q != '1)) statFetched_q <= statFetched_q + 32'd1;
      statDropped_q <= dropSum[32] ? '1 : dropSum[31:0];
    end
  end

  assign bus.stat_fetched = statFetched_q;
  assign bus.stat_dropped = statDropped_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed stimulus with a scoreboard of expected
// {pc, data} words; a negedge monitor pops and compares on each handshake.
module tb_instr_fetch_queue;
  localparam int DATA_W = 72;
  localparam int ADDR_W = 72;
  localparam int DEPTH  = 4;
  localparam logic [71:0] PC_MAX = '1;

  typedef struct {
    logic [71:0] pc;
    logic [71:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   ackEn = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;
  exp_t expQ[$];
  exp_t monEntry;

  instr_fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus();

  instr_fetch_queue #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Memory image: opcode nibble 9 followed by the low address bits.
  function automatic logic [71:0] memWord(input logic [71:0] a);
    return {4'h9, a[67:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectPc(input logic [71:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = memWord(pc);
    expQ.push_back(e);
  endtask

  // Advance n cycles; after each edge the memory model answers the current request.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.imem_ack   = ackEn && bus.imem_req;
      bus.imem_rdata = memWord(bus.imem_addr);
    end
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.instr_valid && bus.instr_ready) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_output: got pc %0h, expected no output", bus.instr_pc);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("out_pc", bus.instr_pc, monEntry.pc);
        checkOutput("out_data", bus.instr_data, monEntry.data);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.redirect_en   = 1'b0;
    bus.redirect_addr = '0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.instr_ready   = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_req",   72'(bus.imem_req), 72'd0);
    checkOutput("rst_addr",  bus.imem_addr, 72'd0);
    checkOutput("rst_valid", 72'(bus.instr_valid), 72'd0);
    checkOutput("rst_count", 72'(bus.count), 72'd0);
    checkOutput("rst_data",  bus.instr_data, 72'd0);
    checkOutput("rst_pc",    bus.instr_pc, 72'd0);

    // Streaming: acks every cycle, decode always ready, addresses 0..7.
    for (int i = 0; i < 8; i++) expectPc(72'(i));
    bus.instr_ready = 1'b1;
    ackEn = 1'b1;
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("s1_req",   72'(bus.imem_req), 72'd1);
    checkOutput("s1_addr",  bus.imem_addr, 72'd0);
    checkOutput("s1_valid", 72'(bus.instr_valid), 72'd0);
    applyStimulus(1);
    checkOutput("s2_valid", 72'(bus.instr_valid), 72'd1);
    checkOutput("s2_pc",    bus.instr_pc, 72'd0);
    checkOutput("s2_addr",  bus.imem_addr, 72'd1);
    applyStimulus(2);
    checkOutput("s4_addr",  bus.imem_addr, 72'd3);
    checkOutput("s4_count", 72'(bus.count), 72'd1);
    applyStimulus(4);
    ackEn = 1'b0;
    applyStimulus(3);
    checkOutput("drain_count", 72'(bus.count), 72'd0);
    checkOutput("drain_addr",  bus.imem_addr, 72'd8);

    // Backpressure: four pushes fill the queue, then requests stop.
    bus.instr_ready = 1'b0;
    ackEn = 1'b1;
    for (int i = 8; i < 12; i++) expectPc(72'(i));
    applyStimulus(5);
    ackEn = 1'b0;
    checkOutput("full_count", 72'(bus.count), 72'd4);
    checkOutput("full_req",   72'(bus.imem_req), 72'd0);
    checkOutput("full_pc",    bus.instr_pc, 72'd8);
    applyStimulus(2);
    checkOutput("hold_pc",    bus.instr_pc, 72'd8);
    checkOutput("hold_data",  bus.instr_data, memWord(72'd8));
    checkOutput("hold_req",   72'(bus.imem_req), 72'd0);
    bus.instr_ready = 1'b1;
    applyStimulus(1);
    bus.instr_ready = 1'b0;
    checkOutput("pop1_count", 72'(bus.count), 72'd3);
    checkOutput("pop1_req",   72'(bus.imem_req), 72'd0);
    applyStimulus(1);
    checkOutput("refill_req",  72'(bus.imem_req), 72'd1);
    checkOutput("refill_addr", bus.imem_addr, 72'd12);
    bus.instr_ready = 1'b1;
    applyStimulus(3);
    checkOutput("empty_count", 72'(bus.count), 72'd0);

    // Redirect to 0x40 while address 12 is outstanding and unacked.
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = 72'h40;
    applyStimulus(1);
    bus.redirect_en = 1'b0;
    checkOutput("drop_req",  72'(bus.imem_req), 72'd1);
    checkOutput("drop_addr", bus.imem_addr, 72'd12);
    applyStimulus(2);
    checkOutput("drop_hold", bus.imem_addr, 72'd12);
    expectPc(72'h40);
    expectPc(72'h41);
    ackEn = 1'b1;
    applyStimulus(2);
    checkOutput("redir_addr", bus.imem_addr, 72'h40);
    applyStimulus(1);
    checkOutput("redir_pc",   bus.instr_pc, 72'h40);
    ackEn = 1'b0;
    applyStimulus(3);
    checkOutput("redir_count", 72'(bus.count), 72'd0);

    // Redirect to 0x80 together with an ack and a pop at count 2.
    bus.instr_ready = 1'b0;
    ackEn = 1'b1;
    expectPc(72'h42);
    applyStimulus(3);
    checkOutput("c2_count", 72'(bus.count), 72'd2);
    checkOutput("c2_addr",  bus.imem_addr, 72'h44);
    bus.instr_ready   = 1'b1;
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = 72'h80;
    applyStimulus(1);
    bus.redirect_en = 1'b0;
    ackEn = 1'b0;
    checkOutput("flush_count", 72'(bus.count), 72'd0);
    checkOutput("flush_valid", 72'(bus.instr_valid), 72'd0);
    checkOutput("flush_req",   72'(bus.imem_req), 72'd0);
    applyStimulus(1);
    checkOutput("r80_req",  72'(bus.imem_req), 72'd1);
    checkOutput("r80_addr", bus.imem_addr, 72'h80);

    // Fetch PC wrap: redirect near the top of the address space.
    bus.redirect_en   = 1'b1;
    bus.redirect_addr = PC_MAX - 72'd1;
    applyStimulus(1);
    bus.redirect_en = 1'b0;
    checkOutput("wrap_drop_addr", bus.imem_addr, 72'h80);
    expectPc(PC_MAX - 72'd1);
    expectPc(PC_MAX);
    expectPc(72'd0);
    expectPc(72'd1);
    ackEn = 1'b1;
    applyStimulus(2);
    checkOutput("wrap_addr", bus.imem_addr, PC_MAX - 72'd1);
    applyStimulus(3);
    ackEn = 1'b0;
    applyStimulus(2);
    checkOutput("wrap_count", 72'(bus.count), 72'd0);
    checkOutput("wrap_next",  bus.imem_addr, 72'd2);

    // Asynchronous reset in the middle of a request with one entry buffered.
    bus.instr_ready = 1'b0;
    ackEn = 1'b1;
    applyStimulus(1);
    ackEn = 1'b0;
    applyStimulus(1);
    checkOutput("pre_rst_count", 72'(bus.count), 72'd1);
    checkOutput("pre_rst_req",   72'(bus.imem_req), 72'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_req",   72'(bus.imem_req), 72'd0);
    checkOutput("arst_count", 72'(bus.count), 72'd0);
    checkOutput("arst_valid", 72'(bus.instr_valid), 72'd0);
    checkOutput("arst_addr",  bus.imem_addr, 72'd0);
    applyStimulus(2);

    checkOutput("scoreboard_left", 72'(expQ.size()), 72'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Sits between the program counter and instruction memory on one side, and the decode stage (register file read, control unit) on the other.
- Owns the fetch PC and issues one-at-a-time requests to instruction memory.
- Buffers returned 72-bit instructions, each with its PC, in a small FIFO and hands them to decode over a valid/ready handshake.
- Flushes itself and re-steers on a branch/jump redirect.

Parameters:
- DATA_W, 72, instruction width (opcode [71:68], rs1 [67:62], rs2 [61:56], rd [55:50], imm [49:0]).
- ADDR_W, 72, fetch PC / instruction memory word-address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 0, fetch PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_en  in  1  branch taken or jump, from the PC/branch logic.
- redirect_addr  in  ADDR_W  new fetch PC.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  ADDR_W  word address of the request.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  DATA_W  fetched instruction.
- instr_valid  out  1  head of FIFO is valid.
- instr_ready  in  1  decode accepts the head.
- instr_data  out  DATA_W  head instruction.
- instr_pc  out  ADDR_W  PC of the head instruction.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; state=IDLE; FIFO empty.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr_data=0, instr_pc=0, count=0.
- States are IDLE, REQ and DROP.
  - IDLE: if count<DEPTH and no redirect this cycle, go to REQ. imem_req rises one cycle after the slot is seen.
  - REQ: imem_req=1 and imem_addr=fetch_pc are held stable until imem_ack.
    - On ack with no redirect: push {imem_rdata, fetch_pc}; fetch_pc+=1.
    - After that ack, if a slot is still free counting this push and any same-cycle pop, stay in REQ (back-to-back, one instruction/cycle max). Otherwise go to IDLE.
  - DROP: a redirect arrived while a request was unacked. imem_req stays 1 with the old imem_addr until imem_ack. The returned data is discarded (not pushed). Then go to IDLE, or to REQ if a slot is free.
- Redirect (redirect_en=1), next-edge effects:
  - FIFO flushed (count=0, instr_valid=0); fetch_pc=redirect_addr.
  - In IDLE: go to IDLE; a new request for redirect_addr is issued the following cycle.
  - In REQ without same-cycle ack: go to DROP.
  - In REQ with same-cycle ack: data discarded, go to IDLE.
  - In DROP: fetch_pc is updated again and the state stays DROP.
  - Redirect has priority over push and over pop. A head popped in the same cycle as a redirect is still counted as consumed by decode.
- Output handshake:
  - instr_valid = (count!=0). instr_data/instr_pc are stable while instr_valid=1 and instr_ready=0.
  - Pop on instr_valid & instr_ready. A push into an empty FIFO is visible at the output the cycle after the ack (1-cycle latency).
- Boundaries:
  - Never request when count==DEPTH, so overflow is impossible.
  - Simultaneous push and pop leaves count unchanged.
  - Pop on empty is ignored.
  - fetch_pc wraps from 2^ADDR_W-1 to 0.
  - FIFO pointers wrap modulo DEPTH.
  - instr_ready is ignored while instr_valid=0.

Optional Feature:
- IFQ_STATS_EN defined: adds outputs stat_fetched[31:0] and stat_dropped[31:0], cleared on reset, saturating at 32'hFFFFFFFF.
  - stat_fetched counts pushes.
  - stat_dropped counts discarded acks plus entries flushed by redirect.
- IFQ_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package proc72_pkg holds:
  - instruction field MSB/LSB constants (OPCODE [71:68], RS1 [67:62], RS2 [61:56], RD [55:50], IMM [49:0], JADDR [54:0]);
  - DATA_W/ADDR_W defaults;
  - the fetch state encoding IFQ_IDLE=2'd0, IFQ_REQ=2'd1, IFQ_DROP=2'd2.
- One sub-module: ifq_fifo, a synchronous DEPTH x (DATA_W+ADDR_W) FIFO with push, pop, flush and count.

Test Plan:
- Reset release, memory acks every cycle, instr_ready=1 → requests to addresses 0,1,2,...; outputs instr_pc=0,1,2,... with matching data, one per cycle after 2-cycle startup.
- instr_ready=0, memory acks every cycle → exactly 4 pushes, count=4, imem_req=0. Raise instr_ready → one pop, then a request for address 4.
- Redirect to 0x40 while in REQ with ack delayed 3 cycles → imem_addr holds the old address until ack; that data is never output; the next request is 0x40; the first output has instr_pc=0x40.
- Redirect to 0x80 in the same cycle as ack and pop with count=2 → next cycle count=0, instr_valid=0; the next request is 0x80.
- Reset with RESET_PC=2^72-2, acks every cycle → instr_pc sequence 2^72-2, 2^72-1, 0, 1.
- Assert rst low mid-REQ → imem_req=0, count=0, instr_valid=0 immediately, without waiting for a clock edge.
